mem_client: RTL and testbench

Initiator for the tape-memory request protocol: takes cell commands (LOAD, STORE, ADD) from the BF core and turns them into single-cell memory transactions. It issues requests with `doit`, honours the responder's `busy`, and captures read data on `rvalid`. ADD is a read-modify-write performed entirely inside the block. The block sits between the core's data-tape path and `mem_sim_delay` or any other responder of the same protocol.

---
 rtl/mem_client_pkg.sv | 8 +
 rtl/mem_client_cache.sv | 25 ++
 rtl/mem_client.sv | 81 ++++++++
 tb/tb_mem_client.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_client_pkg.sv
// mem_client_pkg: command op encodings and FSM state for mem_client
package mem_client_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
endpackage

// File: rtl/mem_client_cache.sv
// mem_client_cache: single-entry cell cache (valid, tag, value) with lookup and update ports
module mem_client_cache #(parameter int aw = 4) (
  input logic clk,
  input logic init_n,
  input logic [aw-1:0] lookup_addr,
  output logic hit,
  output logic [7:0] hit_data,
  input logic upd,
  input logic [aw-1:0] upd_addr,
  input logic [7:0] upd_data
);
  logic valid;
  logic [aw-1:0] tag;
  assign hit = valid && tag == lookup_addr;
  always_ff @(posedge clk)
    if (!init_n) begin
      valid <= 1'b0;
      tag <= '0;
      hit_data <= '0;
    end else if (upd) begin
      valid <= 1'b1;
      tag <= upd_addr;
      hit_data <= upd_data;
    end
endmodule

// File: rtl/mem_client.sv
// mem_client: tape-memory initiator for LOAD/STORE/ADD; MEM_CLIENT_CACHE_EN adds a one-entry cell cache
module mem_client import mem_client_pkg::*; #(parameter int logsize = 4) (
  input logic clk,
  input logic init_n,
  input logic cmd_valid,
  output logic cmd_ready,
  input logic [1:0] cmd_op,
  input logic [logsize-1:0] cmd_addr,
  input logic [7:0] cmd_data,
  output logic rsp_valid,
  output logic [7:0] rsp_data,
  output logic [logsize-1:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic mem_wselect,
  output logic mem_doit,
  input logic mem_busy,
  input logic mem_rvalid,
  input logic [7:0] mem_rdata
);
  state_t state;
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic hit;
  logic [7:0] hit_data;
  assign cmd_ready = state == IDLE;
  assign mem_doit = state == RD_REQ || state == WR_REQ;
  assign mem_wselect = state == WR_REQ;
`ifdef MEM_CLIENT_CACHE_EN
  // coherent only because this block is the sole writer of the tape
  mem_client_cache #(.aw(logsize)) u_cache (
    .clk(clk),
    .init_n(init_n),
    .lookup_addr(cmd_addr),
    .hit(hit),
    .hit_data(hit_data),
    .upd((state == WR_REQ && !mem_busy) || (state == RD_WAIT && mem_rvalid && op_q == OP_LOAD)),
    .upd_addr(mem_addr),
    .upd_data(state == WR_REQ ? mem_wdata : mem_rdata)
  );
`else
  assign hit = 1'b0;
  assign hit_data = 8'h00;
`endif
  always_ff @(posedge clk)
    if (!init_n) begin
      state <= IDLE;
      op_q <= OP_LOAD;
      data_q <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          mem_addr <= cmd_addr;
          data_q <= cmd_data;
          mem_wdata <= cmd_op == OP_STORE ? cmd_data : hit_data + cmd_data;
          rsp_valid <= cmd_op == OP_LOAD && hit;
          if (cmd_op == OP_LOAD && hit) rsp_data <= hit_data;
          state <= cmd_op == OP_STORE || (cmd_op == OP_ADD && hit) ? WR_REQ :
                   (cmd_op == OP_LOAD || cmd_op == OP_ADD) && !hit ? RD_REQ : IDLE;
        end
        RD_REQ: if (!mem_busy) state <= RD_WAIT;
        RD_WAIT: if (mem_rvalid) begin
          mem_wdata <= mem_rdata + data_q;
          rsp_valid <= op_q != OP_ADD;
          if (op_q != OP_ADD) rsp_data <= mem_rdata;
          state <= op_q == OP_ADD ? WR_REQ : IDLE;
        end
        WR_REQ: if (!mem_busy) begin
          rsp_valid <= 1'b1;
          rsp_data <= mem_wdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_client.sv
// tb_mem_client: randomized self-checking bench for mem_client with an inline 3-step responder
module tb_mem_client;
  localparam int LS = 4;
  localparam int S = 3;
`ifdef MEM_CLIENT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  typedef struct {
    int lat;
    int stalls;
    int accs;
    int moves;
    logic [7:0] rd;
    logic doit1;
    logic wsel1;
    logic rdy1;
  } res_t;
  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [LS-1:0] cmd_addr = '0;
  logic [7:0] cmd_data = 8'h00;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic [LS-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic mem_wselect, mem_doit, mem_busy, mem_rvalid;
  logic [7:0] mem_rdata;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_client #(.logsize(LS)) dut (
    .clk(clk), .init_n(init_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wselect(mem_wselect), .mem_doit(mem_doit),
    .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  // responder: busy for S cycles after an accept, read data in the last busy cycle; not reset by init_n
  logic [7:0] mem [16] = '{default: 8'h00};
  int cnt = 0;
  logic rd_pend = 1'b0;
  logic [7:0] rd_val = 8'h00;
  assign mem_busy = cnt != 0;
  assign mem_rvalid = rd_pend && cnt == 1;
  assign mem_rdata = mem_rvalid ? rd_val : 8'h00;
  always @(posedge clk)
    if (mem_doit && !mem_busy) begin
      cnt <= S;
      rd_pend <= !mem_wselect;
      rd_val <= mem[mem_addr];
      if (mem_wselect) mem[mem_addr] <= mem_wdata;
    end else if (cnt != 0) cnt <= cnt - 1;
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic c_valid = 1'b0;
  logic [LS-1:0] c_addr = '0;
  task automatic model(input logic [1:0] op, input logic [LS-1:0] a, input logic [7:0] d,
                       output logic [7:0] e, output int base, output int accs);
    logic h;
    h = CACHE && c_valid && c_addr == a;
    e = op == 2'd0 ? ref_mem[a] : op == 2'd1 ? d : ref_mem[a] + d;
    base = op == 2'd1 ? 2 : h ? (op == 2'd0 ? 1 : 2) : (op == 2'd0 ? S + 2 : S + 3);
    accs = op == 2'd1 ? 1 : op == 2'd0 ? (h ? 0 : 1) : (h ? 1 : 2);
    ref_mem[a] = e;
    c_valid = 1'b1;
    c_addr = a;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(input logic [1:0] op, input logic [LS-1:0] a, input logic [7:0] d, output res_t r);
    int g = 0;
    int lat = 1;
    logic ps = 1'b0;
    logic [LS-1:0] pa = '0;
    r = '{default: 0};
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    r.doit1 = mem_doit;
    r.wsel1 = mem_wselect;
    r.rdy1 = cmd_ready;
    while (lat < 60) begin
      if (mem_doit && mem_busy) r.stalls++;
      if (mem_doit && !mem_busy) r.accs++;
      if (ps && mem_doit && mem_addr != pa) r.moves++;
      ps = mem_doit && mem_busy;
      pa = mem_addr;
      if (rsp_valid) break;
      @(negedge clk);
      lat++;
    end
    r.lat = rsp_valid ? lat : -1;
    r.rd = rsp_data;
  endtask
  task automatic test_reset;
    init_n = 1'b0;
    idle(2);
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", rsp_data); else passed++;
    total++; if (mem_doit !== 1'b0) $display("FAIL reset_mem_doit: got %b want 0", mem_doit); else passed++;
    total++; if (mem_wselect !== 1'b0) $display("FAIL reset_mem_wselect: got %b want 0", mem_wselect); else passed++;
    total++; if (mem_addr !== 4'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else passed++;
    init_n = 1'b1;
    c_valid = 1'b0;
    idle(1);
  endtask
  task automatic test_mid_reset;
    int seen = 0;
    idle(6);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_addr = 4'd3;
    cmd_data = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (mem_doit !== 1'b1) $display("FAIL midrst_read_issued: got %b want 1", mem_doit); else passed++;
    @(negedge clk);
    init_n = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    c_valid = 1'b0;
    total++; if (cmd_ready !== 1'b1) $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); else passed++;
    total++; if ({rsp_valid, rsp_data, mem_addr, mem_wdata, mem_wselect, mem_doit} !== '0)
      $display("FAIL midrst_outputs_zero: got %b want 0", {rsp_valid, rsp_data, mem_addr, mem_wdata, mem_wselect, mem_doit}); else passed++;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_late_rvalid: got %0d responses want 0", seen); else passed++;
  endtask
  task automatic test_store;
    res_t r;
    logic [7:0] e;
    int base, acc;
    idle(6);
    model(2'd1, 4'd5, 8'h2A, e, base, acc);
    issue(2'd1, 4'd5, 8'h2A, r);
    total++; if (r.doit1 !== 1'b1) $display("FAIL store_doit_t1: got %b want 1", r.doit1); else passed++;
    total++; if (r.wsel1 !== 1'b1) $display("FAIL store_wselect_t1: got %b want 1", r.wsel1); else passed++;
    total++; if (r.rdy1 !== 1'b0) $display("FAIL store_cmd_ready_t1: got %b want 0", r.rdy1); else passed++;
    total++; if (r.lat !== 2) $display("FAIL store_latency: got %0d want 2", r.lat); else passed++;
    total++; if (r.rd !== 8'h2A) $display("FAIL store_rsp_data: got %h want 2a", r.rd); else passed++;
  endtask
  task automatic test_load;
    res_t r;
    logic [7:0] e;
    int base, acc;
    idle(6);
    model(2'd0, 4'd5, 8'h00, e, base, acc);
    issue(2'd0, 4'd5, 8'h00, r);
    total++; if (r.wsel1 !== 1'b0) $display("FAIL load_wselect_t1: got %b want 0", r.wsel1); else passed++;
    total++; if (r.lat !== base) $display("FAIL load_latency: got %0d want %0d", r.lat, base); else passed++;
    total++; if (r.rd !== 8'h2A) $display("FAIL load_rsp_data: got %h want 2a", r.rd); else passed++;
    total++; if (r.accs !== acc) $display("FAIL load_mem_accesses: got %0d want %0d", r.accs, acc); else passed++;
  endtask
  task automatic test_add;
    res_t r;
    logic [7:0] e;
    int base, acc;
    idle(6);
    model(2'd2, 4'd5, 8'hFF, e, base, acc);
    issue(2'd2, 4'd5, 8'hFF, r);
    total++; if (r.rd !== 8'h29) $display("FAIL add_dec_rsp_data: got %h want 29", r.rd); else passed++;
    total++; if (r.lat !== base) $display("FAIL add_dec_latency: got %0d want %0d", r.lat, base); else passed++;
    idle(6);
    total++; if (mem[5] !== 8'h29) $display("FAIL add_dec_mem_cell: got %h want 29", mem[5]); else passed++;
    model(2'd1, 4'd5, 8'hFF, e, base, acc);
    issue(2'd1, 4'd5, 8'hFF, r);
    idle(6);
    model(2'd2, 4'd5, 8'h01, e, base, acc);
    issue(2'd2, 4'd5, 8'h01, r);
    total++; if (r.rd !== 8'h00) $display("FAIL add_wrap_rsp_data: got %h want 00", r.rd); else passed++;
    total++; if (r.accs !== acc) $display("FAIL add_wrap_mem_accesses: got %0d want %0d", r.accs, acc); else passed++;
  endtask
  task automatic test_back_to_back;
    res_t r;
    logic [7:0] e;
    int base, acc;
    idle(6);
    model(2'd1, 4'd2, 8'hC3, e, base, acc);
    issue(2'd1, 4'd2, 8'hC3, r);
    idle(6);
    model(2'd1, 4'd1, 8'h5A, e, base, acc);
    issue(2'd1, 4'd1, 8'h5A, r);
    model(2'd0, 4'd2, 8'h00, e, base, acc);
    issue(2'd0, 4'd2, 8'h00, r);
    total++; if (r.stalls !== 2) $display("FAIL b2b_busy_stall: got %0d want 2", r.stalls); else passed++;
    total++; if (r.moves !== 0) $display("FAIL b2b_addr_stable: got %0d changes want 0", r.moves); else passed++;
    total++; if (r.lat !== S + 4) $display("FAIL b2b_latency: got %0d want %0d", r.lat, S + 4); else passed++;
    total++; if (r.rd !== 8'hC3) $display("FAIL b2b_rsp_data: got %h want c3", r.rd); else passed++;
  endtask
  task automatic test_reserved;
    int rsp = 0;
    int doit = 0;
    logic rdy1;
    idle(6);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_addr = 4'd7;
    cmd_data = 8'h11;
    @(negedge clk);
    cmd_valid = 1'b0;
    rdy1 = cmd_ready;
    repeat (8) begin
      if (rsp_valid) rsp++;
      if (mem_doit) doit++;
      @(negedge clk);
    end
    total++; if (rdy1 !== 1'b1) $display("FAIL rsvd_cmd_ready: got %b want 1", rdy1); else passed++;
    total++; if (rsp !== 0) $display("FAIL rsvd_no_response: got %0d want 0", rsp); else passed++;
    total++; if (doit !== 0) $display("FAIL rsvd_no_access: got %0d want 0", doit); else passed++;
  endtask
`ifdef MEM_CLIENT_CACHE_EN
  task automatic test_cache;
    res_t r;
    logic [7:0] e;
    int base, acc;
    idle(6);
    model(2'd0, 4'd5, 8'h00, e, base, acc);
    issue(2'd0, 4'd5, 8'h00, r);
    idle(6);
    model(2'd0, 4'd5, 8'h00, e, base, acc);
    issue(2'd0, 4'd5, 8'h00, r);
    total++; if (r.lat !== 1) $display("FAIL cache_hit_latency: got %0d want 1", r.lat); else passed++;
    total++; if (r.accs !== 0 || r.doit1 !== 1'b0) $display("FAIL cache_hit_no_doit: got %0d want 0", r.accs); else passed++;
    total++; if (r.rd !== e) $display("FAIL cache_hit_data: got %h want %h", r.rd, e); else passed++;
    idle(6);
    model(2'd0, 4'd6, 8'h00, e, base, acc);
    issue(2'd0, 4'd6, 8'h00, r);
    total++; if (r.lat !== S + 2 || r.accs !== 1) $display("FAIL cache_miss: got lat %0d acc %0d want %0d 1", r.lat, r.accs, S + 2); else passed++;
    idle(6);
    model(2'd2, 4'd6, 8'h10, e, base, acc);
    issue(2'd2, 4'd6, 8'h10, r);
    total++; if (r.lat !== 2 || r.rd !== e) $display("FAIL cache_add_hit: got lat %0d data %h want 2 %h", r.lat, r.rd, e); else passed++;
  endtask
`endif
  task automatic test_random;
    res_t r;
    logic [7:0] e, d;
    logic [1:0] op;
    logic [LS-1:0] a = '0;
    int base, acc;
    idle(6);
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) a = LS'($urandom_range(0, 15));
      d = 8'($urandom);
      idle($urandom_range(0, 2));
      model(op, a, d, e, base, acc);
      issue(op, a, d, r);
      total++; if (r.rd !== e) $display("FAIL rand_data[%0d] op%0d: got %h want %h", i, op, r.rd, e); else passed++;
      total++; if (r.lat !== base + r.stalls) $display("FAIL rand_latency[%0d] op%0d: got %0d want %0d", i, op, r.lat, base + r.stalls); else passed++;
      total++; if (r.accs !== acc) $display("FAIL rand_accesses[%0d] op%0d: got %0d want %0d", i, op, r.accs, acc); else passed++;
    end
    idle(6);
    for (int i = 0; i < 16; i++) begin
      total++; if (mem[i] !== ref_mem[i]) $display("FAIL rand_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]); else passed++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_mid_reset;
    test_store;
    test_load;
    test_add;
    test_back_to_back;
    test_reserved;
`ifdef MEM_CLIENT_CACHE_EN
    test_cache;
`endif
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
